battle_turn_sched: RTL and testbench

Turn scheduler for the battle datapath. Each accepted `go` press runs one full round: the player's half-turn, then an AI half-turn.

- Each half-turn selects the move, rolls for accuracy, and then pulses damage calculation and damage application into the datapath.
- After each application it checks the target's HP for a KO.
- The block sits between the push-button/switch inputs and the HP datapath. It drives the datapath control strobes and the victory/loss indicators.

---
 rtl/battle_turn_sched.sv | 152 +++++++++++++++
 tb/tb_battle_turn_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battle_turn_sched.sv
`default_nettype none
// ============================================================================
// battle_turn_sched : one battle round per go press (player half, then AI half)
// Revision 1.0
// ============================================================================
module battle_turn_sched #(
    parameter int         HP_W      = 4,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [1:0]      p_move,
    input  logic [3:0]      accu,
    input  logic [HP_W-1:0] p_hp,
    input  logic [HP_W-1:0] ai_hp,
    output logic [1:0]      move_sel,
    output logic            actr,
    output logic            target,
    output logic            calc_dmg,
    output logic            app_dmg,
    output logic            missed,
    output logic            busy,
    output logic            victory,
    output logic            loss,
    output logic [7:0]      turn_cnt
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        P_ROLL   = 4'd1,
        P_CALC   = 4'd2,
        P_APPLY  = 4'd3,
        P_CHECK  = 4'd4,
        AI_ROLL  = 4'd5,
        AI_CALC  = 4'd6,
        AI_APPLY = 4'd7,
        AI_CHECK = 4'd8,
        WIN      = 4'd9,
        LOSE     = 4'd10
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        go_d;
    logic [7:0]  lfsr;
    logic [1:0]  pm_q;
    logic [1:0]  ai_q;
    logic        missed_q;
    logic [7:0]  turn_q;

    logic        rise;
    logic        hit;
    logic        miss_nx;
    logic        latch_pm;
    logic        latch_ai;
    logic        ai_phase;

    assign rise = go & ~go_d;
    assign hit  = (lfsr[3:0] <= accu);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            go_d     <= 1'b0;
            lfsr     <= LFSR_SEED;
            pm_q     <= 2'd0;
            ai_q     <= 2'd0;
            missed_q <= 1'b0;
            turn_q   <= 8'd0;
        end else begin
            state    <= state_nx;
            go_d     <= go;
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            missed_q <= miss_nx;
            if (latch_pm) begin
                pm_q <= p_move;
                if (turn_q != 8'hFF) begin
                    turn_q <= turn_q + 8'd1;
                end
            end
            // AI move comes from the LFSR as it stands on the hand-over edge
            if (latch_ai) begin
                ai_q <= lfsr[5:4];
            end
        end
    end

    always_comb begin
        state_nx = state;
        miss_nx  = 1'b0;
        latch_pm = 1'b0;
        latch_ai = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nx = P_ROLL;
                    latch_pm = 1'b1;
                end
            end
            P_ROLL: begin
                if (hit) begin
                    state_nx = P_CALC;
                end else begin
                    state_nx = AI_ROLL;
                    miss_nx  = 1'b1;
                    latch_ai = 1'b1;
                end
            end
            P_CALC:  state_nx = P_APPLY;
            P_APPLY: state_nx = P_CHECK;
            P_CHECK: begin
                if (ai_hp == '0) begin
                    state_nx = WIN;
                end else begin
                    state_nx = AI_ROLL;
                    latch_ai = 1'b1;
                end
            end
            AI_ROLL: begin
                if (hit) begin
                    state_nx = AI_CALC;
                end else begin
                    state_nx = IDLE;
                    miss_nx  = 1'b1;
                end
            end
            AI_CALC:  state_nx = AI_APPLY;
            AI_APPLY: state_nx = AI_CHECK;
            AI_CHECK: state_nx = (p_hp == '0) ? LOSE : IDLE;
            WIN:      state_nx = WIN;
            LOSE:     state_nx = LOSE;
            default:  state_nx = IDLE;
        endcase
    end

    assign ai_phase = (state == AI_ROLL) || (state == AI_CALC) ||
                      (state == AI_APPLY) || (state == AI_CHECK);

    assign move_sel = ai_phase ? ai_q : pm_q;
    assign actr     = ai_phase;
    assign target   = ai_phase;
    assign calc_dmg = (state == P_CALC) || (state == AI_CALC);
    assign app_dmg  = (state == P_APPLY) || (state == AI_APPLY);
    assign missed   = missed_q;
    assign busy     = !((state == IDLE) || (state == WIN) || (state == LOSE));
    assign victory  = (state == WIN);
    assign loss     = (state == LOSE);
    assign turn_cnt = turn_q;

endmodule
`default_nettype wire

// File: tb/tb_battle_turn_sched.sv
`default_nettype none
// ============================================================================
// tb_battle_turn_sched : round-schedule model plus directed literal checks
// Revision 1.0
// ============================================================================
module tb_battle_turn_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic [1:0] p_move = 2'd0;
    logic [3:0] accu;
    logic [3:0] dp_php = 4'd0;
    logic [3:0] dp_aihp = 4'd0;
    logic [1:0] move_sel;
    logic       actr, target, calc_dmg, app_dmg, missed, busy, victory, loss;
    logic [7:0] turn_cnt;

    logic [3:0] acc_tab [4];
    logic       hp_load = 1'b0;
    logic [3:0] ld_php = 4'd10;
    logic [3:0] ld_aihp = 4'd10;
    logic [3:0] dmg = 4'd2;

    int errors = 0;
    int checks = 0;
    int c_err = 0;
    int c_chk = 0;

    always #5 clk = ~clk;

    battle_turn_sched #(.HP_W(4), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst), .go(go), .p_move(p_move), .accu(accu),
        .p_hp(dp_php), .ai_hp(dp_aihp), .move_sel(move_sel), .actr(actr),
        .target(target), .calc_dmg(calc_dmg), .app_dmg(app_dmg),
        .missed(missed), .busy(busy), .victory(victory), .loss(loss),
        .turn_cnt(turn_cnt)
    );

    // Combinational move lookup feeding accuracy back from move_sel
    assign accu = acc_tab[move_sel];

    function automatic logic [3:0] hp_sub(input logic [3:0] h, input logic [3:0] d);
        return (h > d) ? h - d : 4'd0;
    endfunction

    function automatic logic [7:0] lstep(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    always @(posedge clk) begin
        if (hp_load) begin
            dp_php  <= ld_php;
            dp_aihp <= ld_aihp;
        end else if (app_dmg) begin
            if (target) dp_php  <= hp_sub(dp_php, dmg);
            else        dp_aihp <= hp_sub(dp_aihp, dmg);
        end
    end

    // ---------------- round-schedule model ----------------
    typedef struct packed {
        logic       busy;
        logic       calc;
        logic       app;
        logic       miss;
        logic       actr;
        logic       tgt;
        logic [1:0] mv;
        logic       vic;
        logic       loss;
    } exp_t;

    exp_t       q[$];
    exp_t       m_cur = '0;
    exp_t       m_rest = '0;
    logic       m_go_d = 1'b0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_turns = 8'd0;
    logic [3:0] m_php = 4'd0;
    logic [3:0] m_aihp = 4'd0;

    function automatic exp_t mk(input logic b, input logic c, input logic a,
                                input logic m, input logic ai, input logic [1:0] mv,
                                input logic v, input logic l);
        exp_t e;
        e = '{busy: b, calc: c, app: a, miss: m, actr: ai, tgt: ai, mv: mv, vic: v, loss: l};
        return e;
    endfunction

    // Lay out every cycle of the round that starts after this edge
    task automatic plan();
        logic [7:0] l;
        logic [1:0] pm, aim;
        logic       pmiss;
        pm = p_move;
        if (m_turns != 8'hFF) m_turns = m_turns + 8'd1;
        l = lstep(m_lfsr);
        q.push_back(mk(1, 0, 0, 0, 0, pm, 0, 0));
        if (l[3:0] <= acc_tab[pm]) begin
            q.push_back(mk(1, 1, 0, 0, 0, pm, 0, 0));
            q.push_back(mk(1, 0, 1, 0, 0, pm, 0, 0));
            l = lstep(lstep(lstep(l)));
            q.push_back(mk(1, 0, 0, 0, 0, pm, 0, 0));
            m_aihp = hp_sub(m_aihp, dmg);
            if (m_aihp == 4'd0) begin
                m_rest = mk(0, 0, 0, 0, 0, pm, 1, 0);
                return;
            end
            pmiss = 1'b0;
        end else begin
            pmiss = 1'b1;
        end
        aim = l[5:4];
        l = lstep(l);
        q.push_back(mk(1, 0, 0, pmiss, 1, aim, 0, 0));
        if (l[3:0] <= acc_tab[aim]) begin
            q.push_back(mk(1, 1, 0, 0, 1, aim, 0, 0));
            q.push_back(mk(1, 0, 1, 0, 1, aim, 0, 0));
            q.push_back(mk(1, 0, 0, 0, 1, aim, 0, 0));
            m_php = hp_sub(m_php, dmg);
            m_rest = mk(0, 0, 0, 0, 0, pm, 0, (m_php == 4'd0));
        end else begin
            q.push_back(mk(0, 0, 0, 1, 0, pm, 0, 0));
            m_rest = mk(0, 0, 0, 0, 0, pm, 0, 0);
        end
    endtask

    always @(posedge clk) begin
        if (hp_load) begin
            m_php  = ld_php;
            m_aihp = ld_aihp;
        end
        if (rst) begin
            q.delete();
            m_go_d  = 1'b0;
            m_lfsr  = 8'hA5;
            m_turns = 8'd0;
            m_rest  = '0;
            m_cur   = '0;
        end else begin
            if (go && !m_go_d && !m_cur.busy && !m_cur.vic && !m_cur.loss)
                plan();
            m_go_d = go;
            m_lfsr = lstep(m_lfsr);
            m_cur  = (q.size() > 0) ? q.pop_front() : m_rest;
        end
    end

    always @(negedge clk) begin
        exp_t a;
        a = {busy, calc_dmg, app_dmg, missed, actr, target, move_sel, victory, loss};
        c_chk = c_chk + 1;
        if (a !== m_cur) begin
            c_err = c_err + 1;
            $display("FAIL outputs t=%0t busy/calc/app/miss/actr/tgt/mv/vic/loss actual=%b required=%b",
                     $time, a, m_cur);
        end
        c_chk = c_chk + 1;
        if (turn_cnt !== m_turns) begin
            c_err = c_err + 1;
            $display("FAIL turn_cnt t=%0t actual=%0d required=%0d", $time, turn_cnt, m_turns);
        end
    end

    // ---------------- directed stimulus ----------------
    logic       cap_busy [1:16];
    logic       cap_calc [1:16];
    logic       cap_app  [1:16];
    logic       cap_miss [1:16];
    logic       cap_actr [1:16];
    logic       cap_vic  [1:16];
    logic       cap_loss [1:16];
    logic [1:0] cap_mv   [1:16];
    logic [7:0] cap_tc   [1:16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Rise sampled at edge 0; slot j holds the cycle after edge j-1
    task automatic press_cap(input bit rel, input int n);
        @(negedge clk);
        if (rel) rst = 1'b0;
        go = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= n; j++) begin
            #1;
            cap_busy[j] = busy;  cap_calc[j] = calc_dmg; cap_app[j] = app_dmg;
            cap_miss[j] = missed; cap_actr[j] = actr;   cap_vic[j] = victory;
            cap_loss[j] = loss;  cap_mv[j] = move_sel;  cap_tc[j] = turn_cnt;
            @(negedge clk);
            if (j == 1) begin
                go = 1'b0;
                p_move = ~p_move;
            end
            @(posedge clk);
        end
    endtask

    task automatic reset_load(input logic [3:0] php, input logic [3:0] aihp, input logic [3:0] d);
        @(negedge clk);
        rst = 1'b1;
        ld_php = php; ld_aihp = aihp; dmg = d; hp_load = 1'b1;
        @(negedge clk);
        hp_load = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) acc_tab[i] = 4'd15;
        hp_load = 1'b1;
        repeat (2) @(negedge clk);
        hp_load = 1'b0;
        chk("reset_outs", {busy, calc_dmg, app_dmg, missed, actr, target, move_sel, victory, loss, turn_cnt}, 0);

        // Full round, both hit, from reset LFSR
        p_move = 2'd2;
        press_cap(1, 10);
        chk("t1_calc2", cap_calc[2], 1);  chk("t1_calc6", cap_calc[6], 1);
        chk("t1_calc3", cap_calc[3], 0);  chk("t1_app3", cap_app[3], 1);
        chk("t1_app7", cap_app[7], 1);    chk("t1_busy8", cap_busy[8], 1);
        chk("t1_busy9", cap_busy[9], 0);  chk("t1_actr4", cap_actr[4], 0);
        chk("t1_actr5", cap_actr[5], 1);  chk("t1_mv2", cap_mv[2], 2);
        chk("t1_mv6", cap_mv[6], 1);      chk("t1_tc9", cap_tc[9], 1);

        // Asynchronous reset while in AI_CALC
        p_move = 2'd2;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pre_calc", calc_dmg, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {busy, calc_dmg, app_dmg, missed, actr, target, move_sel, victory, loss, turn_cnt}, 0);
        go = 1'b0;
        @(negedge clk);
        ld_php = 4'd10; ld_aihp = 4'd10; dmg = 4'd2; hp_load = 1'b1;
        @(negedge clk);
        hp_load = 1'b0;

        // Player miss (lfsr 4A in P_ROLL), AI then hits
        acc_tab[3] = 4'd0;
        p_move = 2'd3;
        press_cap(1, 8);
        chk("m_miss1", cap_miss[1], 0);  chk("m_miss2", cap_miss[2], 1);
        chk("m_miss3", cap_miss[3], 0);  chk("m_calc2", cap_calc[2], 0);
        chk("m_actr2", cap_actr[2], 1);  chk("m_mv2", cap_mv[2], 0);
        chk("m_calc3", cap_calc[3], 1);  chk("m_app4", cap_app[4], 1);
        chk("m_busy6", cap_busy[6], 0);
        acc_tab[3] = 4'd15;

        // Victory
        @(negedge clk);
        ld_php = 4'd10; ld_aihp = 4'd2; dmg = 4'd2; hp_load = 1'b1;
        @(negedge clk);
        hp_load = 1'b0;
        p_move = 2'd1;
        press_cap(0, 12);
        chk("v_vic4", cap_vic[4], 0);   chk("v_vic5", cap_vic[5], 1);
        chk("v_busy5", cap_busy[5], 0); chk("v_actr5", cap_actr[5], 0);
        chk("v_calc6", cap_calc[6], 0); chk("v_app7", cap_app[7], 0);
        press_cap(0, 4);
        chk("v_ign_busy", cap_busy[2], 0); chk("v_ign_vic", cap_vic[3], 1);
        chk("v_ign_tc", cap_tc[1], 2);

        // Loss
        reset_load(4'd2, 4'd10, 4'd2);
        p_move = 2'd2;
        press_cap(1, 12);
        chk("l_loss8", cap_loss[8], 0);  chk("l_loss9", cap_loss[9], 1);
        chk("l_loss12", cap_loss[12], 1); chk("l_vic9", cap_vic[9], 0);
        chk("l_busy9", cap_busy[9], 0);

        // go held high, then a rise during AI_CALC
        reset_load(4'd10, 4'd10, 4'd1);
        @(negedge clk);
        rst = 1'b0;
        go = 1'b1;
        repeat (40) @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold_tc", turn_cnt, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        go = 1'b1;
        repeat (10) @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        chk("aicalc_rise_tc", turn_cnt, 2);

        // Saturation of the round counter
        reset_load(4'd10, 4'd10, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 300; r++) begin
            @(negedge clk);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            repeat (10) @(negedge clk);
        end
        chk("sat_tc", turn_cnt, 8'hFF);
        chk("sat_busy", busy, 0);

        errors = errors + c_err;
        checks = checks + c_chk;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
